modn_counter_ctrl: RTL
======================

Name: modn_counter_ctrl

Overview:
- Controller that configures and sequences a programmable mod-M counter.
- Holds the modulus and mode registers, and runs an IDLE/RUN/PAUSE/DONE FSM driven by start/pause/stop commands.
- Emits terminal-count pulses and a wrap tally.
- Sits between a host/config bus and the counting datapath; replaces free-running mod-N counters where run control is needed.

Parameters:
- WIDTH, 4: counter and modulus width in bits.
- N_DEFAULT, 15: modulus loaded at reset, 1..2^WIDTH-1.
- WRAP_W, 8: width of the wrap tally.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when valid&&ready
- cfg_modulus  in  WIDTH  new modulus M
- cfg_oneshot  in  1  1 = one-shot, 0 = periodic
- cfg_err  out  1  one-cycle pulse, config rejected (M==0)
- cmd_start  in  1  start / resume / restart
- cmd_pause  in  1  freeze count
- cmd_stop  in  1  abort to IDLE
- counter  out  WIDTH  current count, 0..M-1
- tc_pulse  out  1  terminal count this cycle
- busy  out  1  state is RUN or PAUSE
- done  out  1  one-shot completed (level)
- wrap_cnt  out  WRAP_W  wraps since last start, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, counter 0, modulus N_DEFAULT, oneshot 0, wrap_cnt 0, cfg_err 0, done 0, busy 0, tc_pulse 0.
- Command priority per cycle: cmd_stop > cmd_pause > cmd_start.

FSM:
- IDLE:
  - start -> RUN; counter stays 0 on the transition edge; wrap_cnt cleared.
- RUN:
  - Each cycle: counter <= (counter==M-1) ? 0 : counter+1.
  - pause -> PAUSE; counter holds and does not increment that edge.
  - stop -> IDLE; counter 0.
- PAUSE:
  - counter and wrap_cnt hold.
  - start -> RUN, resuming from the held value.
  - stop -> IDLE.
- DONE:
  - counter 0; done = 1.
  - start -> RUN from 0; done clears; wrap_cnt cleared.
  - stop -> IDLE; done clears.

Terminal count:
- tc_pulse = (state==RUN) && (counter==M-1), combinational from registered state.
- The wrap occurs on the edge ending that cycle.
- If pause or stop is sampled in a tc cycle, pause/stop wins: no wrap, wrap_cnt unchanged.
- Periodic mode: on wrap, stay in RUN; wrap_cnt++ saturating at 2^WRAP_W-1.
- One-shot mode: on wrap, go to DONE; counter 0; wrap_cnt = 1.

Configuration:
- cfg_ready = state in {IDLE, DONE}.
- On accept with cfg_modulus != 0: modulus and oneshot update at that edge.
- On accept with cfg_modulus == 0: cfg_err pulses one cycle; registers unchanged.
- cfg_valid while not ready: ignored, no error.
- Simultaneous accept and start in IDLE: the new run uses the new M and mode.

Boundary cases:
- M==1: counter stays 0; tc_pulse high every RUN cycle. One-shot M==1 reaches DONE after one RUN cycle.
- M==2^WIDTH-1: counter wraps from 2^WIDTH-2 to 0; all arithmetic is WIDTH bits, no overflow.
- reset mid-RUN or mid-PAUSE: all state returns to reset values on that edge, including modulus = N_DEFAULT.

Latency:
- Command to state change: 1 cycle.
- counter output is registered.

Decomposition:
- Shared package (modn_pkg):
  - FSM state encoding localparams: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - N_DEFAULT and WIDTH defaults.
- Sub-module modn_core:
  - Mod-M counter with en, clr and modulus inputs; outputs count and tc.
  - The controller owns the FSM, config registers and wrap_cnt, and drives modn_core en/clr.

Test Plan:
- Reset then start, M=15 periodic, run 32 cycles -> counter 0..14,0..14,0,1; tc_pulse at counter=14 twice; wrap_cnt=2.
- Config M=5 one-shot, start -> counter 0,1,2,3,4 then DONE; done=1; counter=0; wrap_cnt=1; busy=0; second start restarts from 0.
- Periodic M=8: pause at counter=3 for 4 cycles -> counter holds 3, busy=1; start resumes at 4. Stop at counter=6 -> IDLE, counter=0.
- Config M=0 in IDLE -> cfg_err one pulse, modulus stays 15. cfg_valid with M=3 while RUN -> cfg_ready=0, ignored.
- M=1 periodic -> counter constant 0, tc_pulse every RUN cycle, wrap_cnt saturates at 255 after 255+ cycles.
- Pause and stop together with tc at counter=M-1 (M=4) -> stop wins, IDLE, counter 0, wrap_cnt unchanged. Reset asserted mid-RUN -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/modn_counter_ctrl_pkg.sv
// Shared definitions for the mod-M counter controller: parameter defaults and
// the run-control FSM state encoding.
package modn_pkg;

  localparam int unsigned WIDTH_DEF     = 4;
  localparam int unsigned N_DEFAULT_DEF = 15;
  localparam int unsigned WRAP_W_DEF    = 8;

  // Run-control states; encoding is fixed so the state register reads back predictably.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/modn_counter_ctrl_core.sv
// modn_core: WIDTH-bit mod-M counting datapath.
// Ports: clk_i/reset_i (sync, active-high), en_i advances the count,
// clr_i forces zero (wins over en_i), modulus_i is M (>= 1),
// count_o is the registered count, tc_o flags count == M-1.
module modn_core
  import modn_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] modulus_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // M is never 0, so M-1 stays inside WIDTH bits.
  assign tc_o    = (count_q == (modulus_i - WIDTH'(1)));
  assign count_o = count_q;

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/modn_counter_ctrl.sv
// modn_counter_ctrl: run controller for a programmable mod-M counter.
// Ports: clk_i, reset_i (sync, active-high); config handshake cfg_valid_i /
// cfg_ready_o with cfg_modulus_i, cfg_oneshot_i, cfg_err_o (reject pulse);
// commands cmd_start_i / cmd_pause_i / cmd_stop_i (stop > pause > start);
// status counter_o, tc_pulse_o, busy_o, done_o, wrap_cnt_o (saturating).
module modn_counter_ctrl
  import modn_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned N_DEFAULT = N_DEFAULT_DEF,
  parameter int unsigned WRAP_W    = WRAP_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [WIDTH-1:0]  cfg_modulus_i,
  input  logic              cfg_oneshot_i,
  output logic              cfg_err_o,
  input  logic              cmd_start_i,
  input  logic              cmd_pause_i,
  input  logic              cmd_stop_i,
  output logic [WIDTH-1:0]  counter_o,
  output logic              tc_pulse_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [WRAP_W-1:0] wrap_cnt_o
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  modulus_q, modulus_d;
  logic              oneshot_q, oneshot_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              cfg_err_q, cfg_err_d;
  logic              core_en, core_clr, core_tc;
  logic              cfg_acc;
  logic              go;

  modn_core #(.WIDTH(WIDTH)) u_core (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (core_en),
    .clr_i     (core_clr),
    .modulus_i (modulus_q),
    .count_o   (counter_o),
    .tc_o      (core_tc)
  );

  assign cfg_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign cfg_acc     = cfg_valid_i && cfg_ready_o;
  // Start only takes effect when neither higher-priority command is present.
  assign go          = cmd_start_i && !cmd_pause_i && !cmd_stop_i;

  assign tc_pulse_o  = (state_q == ST_RUN) && core_tc;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done_o      = (state_q == ST_DONE);
  assign cfg_err_o   = cfg_err_q;
  assign wrap_cnt_o  = wrap_q;

  // Config update, next-state and counter control.
  always_comb begin
    state_d   = state_q;
    modulus_d = modulus_q;
    oneshot_d = oneshot_q;
    wrap_d    = wrap_q;
    cfg_err_d = 1'b0;
    core_en   = 1'b0;
    core_clr  = 1'b0;

    // A zero modulus is rejected and leaves the config registers untouched.
    if (cfg_acc) begin
      if (cfg_modulus_i == '0) begin
        cfg_err_d = 1'b1;
      end else begin
        modulus_d = cfg_modulus_i;
        oneshot_d = cfg_oneshot_i;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_RUN;
          core_clr = 1'b1;
          wrap_d   = '0;
        end
      end
      ST_RUN: begin
        if (cmd_stop_i) begin
          state_d  = ST_IDLE;
          core_clr = 1'b1;
        end else if (cmd_pause_i) begin
          state_d = ST_PAUSE;
        end else begin
          core_en = 1'b1;
          if (core_tc) begin
            if (oneshot_q) begin
              state_d = ST_DONE;
              wrap_d  = WRAP_W'(1);
            end else if (wrap_q != {WRAP_W{1'b1}}) begin
              wrap_d = wrap_q + WRAP_W'(1);
            end
          end
        end
      end
      ST_PAUSE: begin
        if (cmd_stop_i) begin
          state_d  = ST_IDLE;
          core_clr = 1'b1;
        end else if (go) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (cmd_stop_i) begin
          state_d = ST_IDLE;
        end else if (go) begin
          state_d  = ST_RUN;
          core_clr = 1'b1;
          wrap_d   = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        core_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      modulus_q <= WIDTH'(N_DEFAULT);
      oneshot_q <= 1'b0;
      wrap_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      modulus_q <= modulus_d;
      oneshot_q <= oneshot_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule
